// File: rtl/profile_pkg.sv
// Shared definitions for the FIFO profiling readout controller:
// FIFO state codes, controller FSM encoding and the dump word count.
package profile_pkg;

  localparam logic [1:0] FIFO_IDLE = 2'd0;
  localparam logic [1:0] FIFO_CALC = 2'd1;
  localparam logic [1:0] FIFO_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } ctrl_state_t;

  function automatic int unsigned word_count(input int unsigned num_fifos);
    return 3 * num_fifos;
  endfunction

endpackage

// File: rtl/profile_readout_ctrl_if.sv
// Valid/ready readout port carrying one counter word plus its FIFO/state tag.
interface profile_readout_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] out_data;
  logic [3:0]       out_fifo;
  logic [1:0]       out_sel;

  modport master (
    output out_valid, out_data, out_fifo, out_sel,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_fifo, out_sel,
    output out_ready
  );
endinterface

// File: rtl/profile_counter.sv
// Saturating live counter with a shadow register that captures the
// count including the current increment when snap is asserted.
module profile_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  input  logic             snap,
  output logic [CNT_W-1:0] snap_q
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;

  assign cnt_nxt = (inc && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      snap_q <= '0;
    end else begin
      if (snap) snap_q <= cnt_nxt;
      cnt_q <= clr ? '0 : cnt_nxt;
    end
  end

endmodule

// File: rtl/profile_readout_ctrl.sv
// Per-FIFO state-cycle profiler: snapshots all counters on request and
// streams them out FIFO-major (idle, calc, done) over a valid/ready port.
//   state     | meaning
//   ST_IDLE   | counting only; dump_req takes snapshot and starts stream
//   ST_STREAM | out_valid high, one shadow word per accepted transfer
//   ST_DONE   | one-cycle dump_done pulse, then back to ST_IDLE
module profile_readout_ctrl
  import profile_pkg::*;
#(
  parameter int NUM_FIFOS     = 4,
  parameter int CNT_W         = 32,
  parameter int CLEAR_ON_DUMP = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2*NUM_FIFOS-1:0] states,
  input  logic                   enable,
  input  logic                   dump_req,
  output logic                   dump_busy,
  output logic                   dump_done,
  profile_readout_ctrl_if.master out_if
);

  localparam int unsigned NWORDS = word_count(NUM_FIFOS);

  ctrl_state_t      state_q, state_d;
  logic [3:0]       fifo_q, fifo_d;
  logic [1:0]       sel_q, sel_d;
  logic             snap;
  logic             last_word;
  logic             streaming;
  logic [CNT_W-1:0] data_mux;
  logic [CNT_W-1:0] shadow [NUM_FIFOS][3];

  for (genvar i = 0; i < NUM_FIFOS; i++) begin : g_fifo
    for (genvar s = 0; s < 3; s++) begin : g_sel
      localparam logic [1:0] CODE = (s == 0) ? FIFO_IDLE :
                                    (s == 1) ? FIFO_CALC : FIFO_DONE;
      profile_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc    (enable && (states[2*i +: 2] == CODE)),
        .clr    (snap && (CLEAR_ON_DUMP != 0)),
        .snap   (snap),
        .snap_q (shadow[i][s])
      );
    end
  end

  assign last_word = (fifo_q == 4'(NUM_FIFOS - 1)) && (sel_q == 2'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      fifo_q  <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      fifo_q  <= fifo_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fifo_d  = fifo_q;
    sel_d   = sel_q;
    snap    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (dump_req) begin
          snap    = 1'b1;
          state_d = ST_STREAM;
          fifo_d  = '0;
          sel_d   = '0;
        end
      end
      ST_STREAM: begin
        if (out_if.out_ready) begin
          if (last_word) begin
            state_d = ST_DONE;
            fifo_d  = '0;
            sel_d   = '0;
          end else if (sel_q == 2'd2) begin
            sel_d  = '0;
            fifo_d = fifo_q + 4'd1;
          end else begin
            sel_d = sel_q + 2'd1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Word index only moves on a handshake, so the tag and data hold while stalled.
  always_comb begin
    data_mux = '0;
    for (int i = 0; i < NUM_FIFOS; i++) begin
      for (int s = 0; s < 3; s++) begin
        if (fifo_q == 4'(i) && sel_q == 2'(s)) data_mux = shadow[i][s];
      end
    end
  end

  assign streaming        = (state_q == ST_STREAM);
  assign out_if.out_valid = streaming;
  assign out_if.out_data  = streaming ? data_mux : '0;
  assign out_if.out_fifo  = streaming ? fifo_q : '0;
  assign out_if.out_sel   = streaming ? sel_q : '0;
  assign dump_busy        = (state_q != ST_IDLE);
  assign dump_done        = (state_q == ST_DONE);

  initial assert (NWORDS == 3 * NUM_FIFOS);

endmodule
